// File: rtl/ad7606_pkg.sv
// ad7606_pkg
//   Shared definitions for the AD7606 parallel-interface controller:
//   controller state encoding, default timing parameters and a small
//   helper used to size the shared cycle counter.
package ad7606_pkg;

    typedef enum logic [3:0] {
        ST_INIT_RST = 4'd0,
        ST_IDLE     = 4'd1,
        ST_CONVST   = 4'd2,
        ST_WAIT_BH  = 4'd3,
        ST_WAIT_BL  = 4'd4,
        ST_CS_SETUP = 4'd5,
        ST_RD_LOW   = 4'd6,
        ST_RD_HIGH  = 4'd7,
        ST_DONE     = 4'd8
    } ad_state_e;

    localparam int NUM_CH_DEF         = 8;
    localparam int RESET_CYC_DEF      = 5;
    localparam int CONVST_LOW_CYC_DEF = 5;
    localparam int RD_LOW_CYC_DEF     = 3;
    localparam int RD_HIGH_CYC_DEF    = 2;
    localparam int TIMEOUT_CYC_DEF    = 1024;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ad7606_sync.sv
// ad7606_sync
//   Two-flop synchronizer for the asynchronous ADC BUSY line.
//   Ports:
//     clk_i     in  system clock
//     reset_n_i in  async active-low reset (flops clear to 0)
//     async_i   in  asynchronous input
//     sync_o    out synchronized output (2 clocks latency)
module ad7606_sync (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/ad7606_ctrl.sv
// ad7606_ctrl
//   Initiator for the AD7606 8-channel simultaneous-sampling ADC on its
//   16-bit parallel bus. Issues the power-up RESET pulse, starts a
//   conversion with CONVST, waits out BUSY (with timeout), then reads the
//   NUM_CH words through CS/RD and emits them as channel-tagged samples.
//   Ports:
//     clk_i, reset_n_i          clock, async active-low reset
//     start_i                   conversion request (acted on in IDLE only)
//     os_cfg_i                  oversampling ratio, copied to ad_os_o in IDLE
//     ad_reset_o, ad_convst_o   ADC RESET / CONVST
//     ad_busy_i                 ADC BUSY (asynchronous)
//     ad_cs_n_o, ad_rd_n_o      ADC chip select / read strobe
//     ad_db_i, ad_frstdata_i    ADC data bus and first-channel flag
//     ad_os_o                   ADC OS[2:0]
//     sample_o, sample_ch_o     captured word and its channel
//     sample_valid_o            1-cycle strobe per captured word
//     frame_done_o              1-cycle strobe after the last word
//     busy_o                    high whenever the controller is not IDLE
//     err_o                     sticky timeout / FRSTDATA error flag
//   Every output is a flop; output next-values are derived from the
//   next state so the ADC pins change on the same edge as the state.
module ad7606_ctrl
    import ad7606_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_DEF,
    parameter int RESET_CYC      = RESET_CYC_DEF,
    parameter int CONVST_LOW_CYC = CONVST_LOW_CYC_DEF,
    parameter int RD_LOW_CYC     = RD_LOW_CYC_DEF,
    parameter int RD_HIGH_CYC    = RD_HIGH_CYC_DEF,
    parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [2:0]  os_cfg_i,
    output logic        ad_reset_o,
    output logic        ad_convst_o,
    input  logic        ad_busy_i,
    output logic        ad_cs_n_o,
    output logic        ad_rd_n_o,
    input  logic [15:0] ad_db_i,
    input  logic        ad_frstdata_i,
    output logic [2:0]  ad_os_o,
    output logic [15:0] sample_o,
    output logic [2:0]  sample_ch_o,
    output logic        sample_valid_o,
    output logic        frame_done_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int CNT_MAX = max_of(max_of(max_of(RESET_CYC, CONVST_LOW_CYC),
                                           max_of(RD_LOW_CYC, RD_HIGH_CYC)),
                                    TIMEOUT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] CONVST_LAST  = CNT_W'(CONVST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOW_LAST  = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RD_HIGH_LAST = CNT_W'(RD_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       CH_LAST      = 3'(NUM_CH - 1);

    ad_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ch_q, ch_d;

    logic        ad_reset_q, ad_reset_d;
    logic        ad_convst_q, ad_convst_d;
    logic        ad_cs_n_q, ad_cs_n_d;
    logic        ad_rd_n_q, ad_rd_n_d;
    logic [2:0]  ad_os_q, ad_os_d;
    logic [15:0] sample_q, sample_d;
    logic [2:0]  sample_ch_q, sample_ch_d;
    logic        sample_valid_q, sample_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic busy_sync;
    logic timeout;
    logic capture;
    logic frst_bad;

    ad7606_sync u_busy_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (ad_busy_i),
        .sync_o    (busy_sync)
    );

    // Timeout fires on the last allowed cycle of a BUSY wait that has not
    // yet seen the edge it is waiting for.
    assign timeout = (cnt_q == TIMEOUT_LAST) &&
                     (((state_q == ST_WAIT_BH) && !busy_sync) ||
                      ((state_q == ST_WAIT_BL) &&  busy_sync));
    assign capture  = (state_q == ST_RD_LOW) && (cnt_q == RD_LOW_LAST);
    assign frst_bad = (ch_q == 3'd0) ? !ad_frstdata_i : ad_frstdata_i;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_INIT_RST;
            cnt_q          <= '0;
            ch_q           <= 3'd0;
            ad_reset_q     <= 1'b1;
            ad_convst_q    <= 1'b1;
            ad_cs_n_q      <= 1'b1;
            ad_rd_n_q      <= 1'b1;
            ad_os_q        <= 3'd0;
            sample_q       <= 16'd0;
            sample_ch_q    <= 3'd0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b1;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ch_q           <= ch_d;
            ad_reset_q     <= ad_reset_d;
            ad_convst_q    <= ad_convst_d;
            ad_cs_n_q      <= ad_cs_n_d;
            ad_rd_n_q      <= ad_rd_n_d;
            ad_os_q        <= ad_os_d;
            sample_q       <= sample_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    // Next-state logic; cnt is shared by every timed state and restarts
    // from zero on each transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        ch_d    = ch_q;
        case (state_q)
            ST_INIT_RST: if (cnt_q == RESET_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i) state_d = ST_CONVST;
            end
            ST_CONVST: if (cnt_q == CONVST_LAST) begin
                state_d = ST_WAIT_BH;
                cnt_d   = '0;
            end
            ST_WAIT_BH: if (busy_sync) begin
                state_d = ST_WAIT_BL;
                cnt_d   = '0;
            end else if (timeout) begin
                state_d = ST_INIT_RST;
                cnt_d   = '0;
            end
            ST_WAIT_BL: if (!busy_sync) begin
                state_d = ST_CS_SETUP;
                cnt_d   = '0;
            end else if (timeout) begin
                state_d = ST_INIT_RST;
                cnt_d   = '0;
            end
            ST_CS_SETUP: begin
                state_d = ST_RD_LOW;
                cnt_d   = '0;
                ch_d    = 3'd0;
            end
            ST_RD_LOW: if (capture) begin
                state_d = (ch_q == CH_LAST) ? ST_DONE : ST_RD_HIGH;
                cnt_d   = '0;
            end
            ST_RD_HIGH: if (cnt_q == RD_HIGH_LAST) begin
                state_d = ST_RD_LOW;
                cnt_d   = '0;
                ch_d    = ch_q + 3'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_INIT_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic (registered through the *_q flops above)
    always_comb begin
        ad_reset_d     = (state_d == ST_INIT_RST);
        ad_convst_d    = (state_d != ST_CONVST);
        ad_cs_n_d      = !((state_d == ST_CS_SETUP) || (state_d == ST_RD_LOW) ||
                           (state_d == ST_RD_HIGH));
        ad_rd_n_d      = (state_d != ST_RD_LOW);
        ad_os_d        = (state_q == ST_IDLE) ? os_cfg_i : ad_os_q;
        sample_d       = capture ? ad_db_i : sample_q;
        sample_ch_d    = capture ? ch_q : sample_ch_q;
        sample_valid_d = capture;
        // One clock after the last sample strobe.
        frame_done_d   = (state_q == ST_DONE);
        busy_d         = (state_d != ST_IDLE);
        err_d          = err_q;
        if ((state_q == ST_IDLE) && start_i) err_d = 1'b0;
        if (timeout)                         err_d = 1'b1;
        if (capture && frst_bad)             err_d = 1'b1;
    end

    assign ad_reset_o     = ad_reset_q;
    assign ad_convst_o    = ad_convst_q;
    assign ad_cs_n_o      = ad_cs_n_q;
    assign ad_rd_n_o      = ad_rd_n_q;
    assign ad_os_o        = ad_os_q;
    assign sample_o       = sample_q;
    assign sample_ch_o    = sample_ch_q;
    assign sample_valid_o = sample_valid_q;
    assign frame_done_o   = frame_done_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_ad7606_ctrl.sv
// tb_ad7606_ctrl
//   Directed bench for ad7606_ctrl with a behavioural AD7606 model
//   (BUSY pulse after CONVST, data 16'h1000+k on word k, FRSTDATA on word 0)
//   and a sample scoreboard.
module tb_ad7606_ctrl;

    logic        clk;
    logic        reset_n_i;
    logic        start_i;
    logic [2:0]  os_cfg_i;
    logic        ad_reset_o;
    logic        ad_convst_o;
    logic        ad_busy_i;
    logic        ad_cs_n_o;
    logic        ad_rd_n_o;
    logic [15:0] ad_db_i;
    logic        ad_frstdata_i;
    logic [2:0]  ad_os_o;
    logic [15:0] sample_o;
    logic [2:0]  sample_ch_o;
    logic        sample_valid_o;
    logic        frame_done_o;
    logic        busy_o;
    logic        err_o;

    ad7606_ctrl dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .start_i        (start_i),
        .os_cfg_i       (os_cfg_i),
        .ad_reset_o     (ad_reset_o),
        .ad_convst_o    (ad_convst_o),
        .ad_busy_i      (ad_busy_i),
        .ad_cs_n_o      (ad_cs_n_o),
        .ad_rd_n_o      (ad_rd_n_o),
        .ad_db_i        (ad_db_i),
        .ad_frstdata_i  (ad_frstdata_i),
        .ad_os_o        (ad_os_o),
        .sample_o       (sample_o),
        .sample_ch_o    (sample_ch_o),
        .sample_valid_o (sample_valid_o),
        .frame_done_o   (frame_done_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_tests   = 0;
    int n_fail    = 0;
    int n_samples = 0;
    int n_frames  = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- ADC model ----------------
    logic model_busy_en   = 1'b1;
    logic force_frst_low  = 1'b0;
    int   idx             = 0;

    initial ad_busy_i = 1'b0;

    always @(posedge ad_convst_o) begin
        if (reset_n_i === 1'b1 && model_busy_en) begin
            #20;
            ad_busy_i = 1'b1;
            #200;
            ad_busy_i = 1'b0;
        end
    end

    always @(negedge ad_cs_n_o) idx = 0;
    always @(posedge ad_rd_n_o) if (ad_cs_n_o === 1'b0) idx = idx + 1;

    assign ad_db_i       = (!ad_cs_n_o && !ad_rd_n_o) ? 16'h1000 + 16'(idx) : 16'hDEAD;
    assign ad_frstdata_i = !ad_cs_n_o && !ad_rd_n_o && (idx == 0) && !force_frst_low;

    // ---------------- monitor ----------------
    logic        prev_last = 1'b0;
    int          conv_lo   = 0;
    int          rd_lo     = 0;
    logic [18:0] exp_v;

    always @(negedge clk) begin
        if (sample_valid_o) begin
            check("sb_has_exp", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                check("sample_ch", 32'(sample_ch_o), 32'(exp_v[18:16]));
                check("sample_data", 32'(sample_o), 32'(exp_v[15:0]));
            end
            n_samples++;
        end
        if (frame_done_o) begin
            check("done_after_last", 32'(prev_last), 1);
            n_frames++;
        end
        prev_last = sample_valid_o && (sample_ch_o == 3'd7);
        if (!reset_n_i) begin
            conv_lo = 0;
            rd_lo   = 0;
        end else begin
            if (!ad_convst_o) conv_lo++;
            else if (conv_lo != 0) begin
                check("convst_low_cyc", conv_lo, 5);
                conv_lo = 0;
            end
            if (!ad_rd_n_o) rd_lo++;
            else if (rd_lo != 0) begin
                check("rd_low_cyc", rd_lo, 3);
                rd_lo = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame();
        for (int k = 0; k < 8; k++) exp_q.push_back({3'(k), 16'h1000 + 16'(k)});
    endtask

    task automatic pulse_start(input string tag);
        start_i = 1'b1;
        wait_clk(1);
        start_i = 1'b0;
        check({tag, "_err_clr_on_accept"}, 32'(err_o), 0);
        check({tag, "_busy_on_accept"}, 32'(busy_o), 1);
    endtask

    task automatic wait_frame(input string tag, input int f0, input int s0);
        int n;
        n = 0;
        while (n_frames == f0 && n < 2000) begin
            wait_clk(1);
            n++;
        end
        check({tag, "_frames"}, n_frames - f0, 1);
        check({tag, "_samples"}, n_samples - s0, 8);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input string tag);
        int f0, s0;
        f0 = n_frames;
        s0 = n_samples;
        push_frame();
        pulse_start(tag);
        wait_frame(tag, f0, s0);
    endtask

    task automatic wait_reset_pulse(input string tag);
        int n;
        n = 0;
        while (ad_reset_o && n < 20) begin
            wait_clk(1);
            n++;
        end
        check({tag, "_reset_cycles"}, n, 5);
        check({tag, "_idle_busy"}, 32'(busy_o), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, f0, s0;
        reset_n_i = 1'b0;
        start_i   = 1'b0;
        os_cfg_i  = 3'b000;

        // 1: reset values and power-up RESET pulse
        #20;
        check("rst_ad_reset", 32'(ad_reset_o), 1);
        check("rst_convst", 32'(ad_convst_o), 1);
        check("rst_cs_n", 32'(ad_cs_n_o), 1);
        check("rst_rd_n", 32'(ad_rd_n_o), 1);
        check("rst_os", 32'(ad_os_o), 0);
        check("rst_valid", 32'(sample_valid_o), 0);
        check("rst_done", 32'(frame_done_o), 0);
        check("rst_busy", 32'(busy_o), 1);
        check("rst_err", 32'(err_o), 0);
        check("rst_sample", 32'(sample_o), 0);
        #30;
        reset_n_i = 1'b1;
        wait_reset_pulse("init");

        // 2: nominal frame, OS copied in IDLE
        os_cfg_i = 3'b010;
        wait_clk(2);
        run_frame("frame1");
        check("frame1_err", 32'(err_o), 0);
        check("frame1_os", 32'(ad_os_o), 3'b010);

        // 3: BUSY never rises -> timeout, ADC re-reset, no samples
        model_busy_en = 1'b0;
        s0 = n_samples;
        f0 = n_frames;
        pulse_start("tmo");
        n = 0;
        while (!err_o && n < 1200) begin
            wait_clk(1);
            n++;
        end
        check("tmo_cycles", n, 1029);
        check("tmo_err", 32'(err_o), 1);
        check("tmo_ad_reset", 32'(ad_reset_o), 1);
        wait_reset_pulse("tmo");
        check("tmo_no_samples", n_samples - s0, 0);
        check("tmo_no_done", n_frames - f0, 0);
        check("tmo_err_sticky", 32'(err_o), 1);
        model_busy_en = 1'b1;

        // 4: FRSTDATA missing on ch0 -> full frame, err set; next start clears
        force_frst_low = 1'b1;
        run_frame("frst");
        check("frst_err", 32'(err_o), 1);
        force_frst_low = 1'b0;
        run_frame("frst_clr");
        check("frst_clr_err", 32'(err_o), 0);

        // 5: start and OS change mid-frame are not acted on until IDLE
        os_cfg_i = 3'b000;
        wait_clk(2);
        check("os_idle_zero", 32'(ad_os_o), 0);
        f0 = n_frames;
        s0 = n_samples;
        push_frame();
        pulse_start("mid");
        n = 0;
        while (ad_cs_n_o && n < 500) begin
            wait_clk(1);
            n++;
        end
        check("mid_cs_low", 32'(ad_cs_n_o), 0);
        start_i  = 1'b1;
        os_cfg_i = 3'b011;
        wait_clk(1);
        start_i  = 1'b0;
        wait_clk(3);
        check("mid_os_hold", 32'(ad_os_o), 0);
        wait_frame("mid", f0, s0);
        wait_clk(30);
        check("mid_no_extra_frame", n_frames - f0, 1);
        check("mid_idle", 32'(busy_o), 0);
        check("mid_os_idle", 32'(ad_os_o), 3'b011);

        // 6: reset during RD_LOW of ch 4 aborts at once, then a clean frame
        s0 = n_samples;
        push_frame();
        pulse_start("abort");
        n = 0;
        while (n_samples - s0 < 4 && n < 500) begin
            wait_clk(1);
            n++;
        end
        n = 0;
        while (ad_rd_n_o && n < 20) begin
            wait_clk(1);
            n++;
        end
        check("abort_rd_low_ch4", 32'(ad_rd_n_o), 0);
        reset_n_i = 1'b0;
        #1;
        check("abort_cs_n", 32'(ad_cs_n_o), 1);
        check("abort_rd_n", 32'(ad_rd_n_o), 1);
        check("abort_ad_reset", 32'(ad_reset_o), 1);
        check("abort_samples", n_samples - s0, 4);
        exp_q.delete();
        wait_clk(3);
        reset_n_i = 1'b1;
        wait_reset_pulse("abort");
        run_frame("after_abort");
        check("after_abort_err", 32'(err_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
